// File: rtl/result_display_driver.sv
// Result display driver: captures a sign-magnitude result over valid/ready,
// blanks briefly on each new result, then scans it onto a 2-digit 7-segment display.
module result_display_driver #(
  parameter int unsigned SCAN_DIV     = 1000,
  parameter int unsigned BLANK_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       res_valid,
  output logic       res_ready,
  input  logic [2:0] res_mag,
  input  logic       res_sign,
  input  logic       res_zero,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       err
);

  localparam int unsigned SCAN_W  = $clog2(SCAN_DIV + 1);
  localparam int unsigned BLANK_W = $clog2(BLANK_CYCLES + 1);

  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_OFF   = 7'h00;
  localparam logic [1:0] AN_DIG0   = 2'b01;
  localparam logic [1:0] AN_DIG1   = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_t;

  state_t             state, nxt_state;
  logic [2:0]         mag, nxt_mag;
  logic               sign, nxt_sign;
  logic [SCAN_W-1:0]  scan_cnt, nxt_scan_cnt;
  logic               dig, nxt_dig;
  logic [BLANK_W-1:0] blank_cnt, nxt_blank_cnt;
  logic               nxt_err;
  logic               nxt_ready;
  logic [6:0]         nxt_seg;
  logic [1:0]         nxt_an;
  logic               accept;

  // 7-segment encoding for magnitudes 0..7, segments {g,f,e,d,c,b,a}
  function automatic logic [6:0] hex7(input logic [2:0] v);
    logic [6:0] s;
    case (v)
      3'd0:    s = 7'h3F;
      3'd1:    s = 7'h06;
      3'd2:    s = 7'h5B;
      3'd3:    s = 7'h4F;
      3'd4:    s = 7'h66;
      3'd5:    s = 7'h6D;
      3'd6:    s = 7'h7D;
      3'd7:    s = 7'h07;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  assign accept = res_valid && res_ready;

  // Next-state, capture and output decode; outputs are registered from next-state values
  always_comb begin
    nxt_state     = state;
    nxt_mag       = mag;
    nxt_sign      = sign;
    nxt_scan_cnt  = scan_cnt;
    nxt_dig       = dig;
    nxt_blank_cnt = blank_cnt;
    nxt_err       = err;
    nxt_ready     = 1'b1;
    nxt_seg       = SEG_DASH;
    nxt_an        = AN_DIG0;

    if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
      nxt_scan_cnt = '0;
      nxt_dig      = ~dig;
    end else begin
      nxt_scan_cnt = scan_cnt + SCAN_W'(1);
    end

    case (state)
      IDLE: begin
        if (accept) nxt_state = BLANK;
      end
      BLANK: begin
        if (blank_cnt == '0) nxt_state = SHOW;
        else                 nxt_blank_cnt = blank_cnt - BLANK_W'(1);
      end
      SHOW: begin
        if (accept) nxt_state = BLANK;
      end
      default: nxt_state = IDLE;
    endcase

    // Zero flag forces an unsigned zero so negative zero never reaches the display
    if (accept) begin
      nxt_mag       = res_zero ? 3'd0 : res_mag;
      nxt_sign      = res_zero ? 1'b0 : res_sign;
      nxt_err       = (res_zero != (res_mag == 3'd0));
      nxt_blank_cnt = BLANK_W'(BLANK_CYCLES - 1);
    end

    nxt_ready = (nxt_state != BLANK);
    nxt_an    = nxt_dig ? AN_DIG1 : AN_DIG0;

    case (nxt_state)
      IDLE:    nxt_seg = SEG_DASH;
      BLANK:   nxt_seg = SEG_OFF;
      SHOW:    nxt_seg = nxt_dig ? (nxt_sign ? SEG_DASH : SEG_OFF) : hex7(nxt_mag);
      default: nxt_seg = SEG_DASH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mag       <= 3'd0;
      sign      <= 1'b0;
      scan_cnt  <= '0;
      dig       <= 1'b0;
      blank_cnt <= '0;
      err       <= 1'b0;
      res_ready <= 1'b1;
      seg       <= SEG_DASH;
      an        <= AN_DIG0;
    end else begin
      state     <= nxt_state;
      mag       <= nxt_mag;
      sign      <= nxt_sign;
      scan_cnt  <= nxt_scan_cnt;
      dig       <= nxt_dig;
      blank_cnt <= nxt_blank_cnt;
      err       <= nxt_err;
      res_ready <= nxt_ready;
      seg       <= nxt_seg;
      an        <= nxt_an;
    end
  end

endmodule
